// File: rtl/ryuki_datatypes.sv
// rtl/ryuki_datatypes.sv - shared trace record type, FSM states and timestamp helpers
package ryuki_datatypes;

  typedef struct packed {
    logic               valid;
    logic        [31:0] addr;
    logic        [31:0] instruction;
    logic        [31:0] mem_addr;
    logic               is_mem;
    logic signed [31:0] if_start;
    logic signed [31:0] if_end;
    logic signed [31:0] id_start;
    logic signed [31:0] id_end;
    logic signed [31:0] ex_start;
    logic signed [31:0] ex_end;
  } trace_output;

  // Timestamp meaning "not yet observed"; matches the counter value right after reset.
  localparam logic signed [31:0] NO_TIME = -32'sd1;

  localparam trace_output TRACE_RESET = '{
    valid: 1'b0, addr: 32'h0, instruction: 32'h0, mem_addr: 32'h0, is_mem: 1'b0,
    if_start: NO_TIME, if_end: NO_TIME, id_start: NO_TIME,
    id_end: NO_TIME, ex_start: NO_TIME, ex_end: NO_TIME
  };

  typedef enum logic [1:0] {
    IF_IDLE,
    IF_WAIT_GNT,
    IF_WAIT_RVALID
  } if_state_e;

  function automatic logic signed [31:0] later_of(input logic signed [31:0] a,
                                                  input logic signed [31:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ex_tracker.sv
// rtl/ex_tracker.sv - queues decoded records and timestamps their execution
module ex_tracker
  import ryuki_datatypes::*;
#(
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int EX_FIFO_DEPTH   = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [31:0]         counter,
  input  logic                       id_data_ready,
  input  trace_output                id_data_o,
  input  logic                       ex_ready,
  input  logic                       data_mem_req,
  input  logic                       data_mem_grant,
  input  logic                       data_mem_rvalid,
  input  logic [DATA_ADDR_WIDTH-1:0] data_mem_addr,
  input  logic signed [31:0]         wb_previous_end_i,
  output logic                       ex_data_ready,
  output trace_output                ex_data_o,
  output logic                       ex_overflow
);

  localparam int PTR_W = $clog2(EX_FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  trace_output        fifo_mem [EX_FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr, rd_ptr;
  logic               empty, full;
  logic               active, waiting;
  logic signed [31:0] cur_start, start_now;
  logic        [31:0] cur_mem_addr;
  logic               head_valid, mem_go, complete, push, pop, write;
  trace_output        head, finished;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // An empty queue lets the incoming decode record act as head in its arrival cycle
  always_comb begin
    head_valid = !empty || id_data_ready;
    head       = empty ? id_data_o : fifo_mem[rd_ptr[PTR_W-1:0]];
    start_now  = active ? cur_start : later_of(head.id_end, wb_previous_end_i);
    mem_go     = head_valid && !waiting && data_mem_req && data_mem_grant;
    complete   = head_valid && (waiting ? data_mem_rvalid : (ex_ready && !mem_go));
    pop        = complete && !empty;
    push       = id_data_ready && !(empty && complete);
    write      = push && (!full || pop);
    finished          = head;
    finished.valid    = 1'b1;
    finished.ex_start = start_now;
    finished.ex_end   = counter;
    if (waiting) begin
      finished.mem_addr = cur_mem_addr;
      finished.is_mem   = 1'b1;
    end
  end

  // Queue storage; no reset needed since the pointers define what is valid
  always_ff @(posedge clk) begin
    if (write) fifo_mem[wr_ptr[PTR_W-1:0]] <= id_data_o;
  end

  // Pointers, head execution state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      active        <= 1'b0;
      waiting       <= 1'b0;
      cur_start     <= NO_TIME;
      cur_mem_addr  <= '0;
      ex_overflow   <= 1'b0;
      ex_data_ready <= 1'b0;
      ex_data_o     <= TRACE_RESET;
    end else begin
      if (write) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (push && full && !pop) ex_overflow <= 1'b1;
      ex_data_ready <= complete;
      if (complete) begin
        ex_data_o <= finished;
        active    <= 1'b0;
        waiting   <= 1'b0;
      end else if (head_valid) begin
        active    <= 1'b1;
        cur_start <= start_now;
        if (mem_go) begin
          waiting      <= 1'b1;
          cur_mem_addr <= 32'(data_mem_addr);
        end
      end
    end
  end

endmodule

// File: rtl/id_tracker.sv
// rtl/id_tracker.sv - holds the latest fetch record and timestamps its decode
module id_tracker
  import ryuki_datatypes::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] counter,
  input  logic               if_data_valid,
  input  trace_output        if_data_o,
  input  logic               id_ready,
  input  logic               jump_done,
  input  logic               is_decoding,
  input  logic               illegal_instruction,
  output logic               id_data_ready,
  output trace_output        id_data_o
);

  logic               held, started;
  logic               cur_valid, decode_now, finish;
  logic signed [31:0] start_t;
  trace_output        rec, cur, decoded;

  // A record arriving this cycle is decodable at once and replaces any held one
  always_comb begin
    cur_valid        = held || if_data_valid;
    cur              = if_data_valid ? if_data_o : rec;
    start_t          = (started && !if_data_valid) ? rec.id_start : counter;
    decode_now       = cur_valid && is_decoding;
    finish           = decode_now && id_ready;
    decoded          = cur;
    decoded.id_start = start_t;
    decoded.id_end   = counter;
  end

  // Holding register lifecycle: load, start decode, complete, or discard
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held          <= 1'b0;
      started       <= 1'b0;
      rec           <= TRACE_RESET;
      id_data_ready <= 1'b0;
      id_data_o     <= TRACE_RESET;
    end else begin
      id_data_ready <= finish && !illegal_instruction;
      if (finish && !illegal_instruction) id_data_o <= decoded;
      if (finish) begin
        held    <= 1'b0;
        started <= 1'b0;
      end else if (decode_now) begin
        rec     <= decoded;
        held    <= 1'b1;
        started <= 1'b1;
      end else if (cur_valid && jump_done) begin
        held    <= 1'b0;
        started <= 1'b0;
      end else if (if_data_valid) begin
        rec     <= if_data_o;
        held    <= 1'b1;
        started <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/if_tracker.sv
// rtl/if_tracker.sv - follows the instruction fetch handshake and emits one record per fetch
module if_tracker
  import ryuki_datatypes::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] counter,
  input  logic               instr_req,
  input  logic               instr_grant,
  input  logic               instr_rvalid,
  input  logic        [31:0] instr_addr,
  input  logic        [31:0] instr_rdata,
  output logic               if_data_valid,
  output trace_output        if_data_o
);

  if_state_e          state, next_state;
  logic               take_start, take_addr, done;
  logic signed [31:0] start_q;
  logic        [31:0] addr_q;
  trace_output        fetched;

  // Next state and capture strobes; req, grant and rvalid may all land in one cycle
  always_comb begin
    next_state = state;
    take_start = 1'b0;
    take_addr  = 1'b0;
    done       = 1'b0;
    case (state)
      IF_IDLE: begin
        if (instr_req) begin
          take_start = 1'b1;
          if (instr_grant) begin
            take_addr  = 1'b1;
            done       = instr_rvalid;
            next_state = instr_rvalid ? IF_IDLE : IF_WAIT_RVALID;
          end else begin
            next_state = IF_WAIT_GNT;
          end
        end
      end
      IF_WAIT_GNT: begin
        if (instr_req && instr_grant) begin
          take_addr  = 1'b1;
          done       = instr_rvalid;
          next_state = instr_rvalid ? IF_IDLE : IF_WAIT_RVALID;
        end
      end
      IF_WAIT_RVALID: begin
        if (instr_rvalid) begin
          done       = 1'b1;
          next_state = IF_IDLE;
        end
      end
      default: next_state = IF_IDLE;
    endcase
  end

  // Record assembled from the values captured this cycle or earlier in the fetch
  always_comb begin
    fetched             = TRACE_RESET;
    fetched.valid       = 1'b1;
    fetched.addr        = take_addr ? instr_addr : addr_q;
    fetched.instruction = instr_rdata;
    fetched.if_start    = take_start ? counter : start_q;
    fetched.if_end      = counter;
  end

  // State register, fetch bookkeeping and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IF_IDLE;
      start_q       <= NO_TIME;
      addr_q        <= '0;
      if_data_valid <= 1'b0;
      if_data_o     <= TRACE_RESET;
    end else begin
      state         <= next_state;
      if_data_valid <= done;
      if (take_start) start_q <= counter;
      if (take_addr) addr_q <= instr_addr;
      if (done) if_data_o <= fetched;
    end
  end

endmodule

// File: rtl/if_id_ex_tracker.sv
// rtl/if_id_ex_tracker.sv - passive IF/ID/EX trace capture wrapper
module if_id_ex_tracker
  import ryuki_datatypes::*;
#(
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int EX_FIFO_DEPTH   = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [31:0]         counter,
  input  logic                       if_busy,
  input  logic                       if_ready,
  input  logic                       instr_req,
  input  logic                       instr_grant,
  input  logic                       instr_rvalid,
  input  logic [31:0]                instr_addr,
  input  logic [31:0]                instr_rdata,
  input  logic                       id_ready,
  input  logic                       jump_done,
  input  logic                       is_decoding,
  input  logic                       illegal_instruction,
  input  logic                       ex_ready,
  input  logic                       data_mem_req,
  input  logic                       data_mem_grant,
  input  logic                       data_mem_rvalid,
  input  logic [DATA_ADDR_WIDTH-1:0] data_mem_addr,
  input  logic signed [31:0]         wb_previous_end_i,
  output logic                       if_data_valid,
  output trace_output                if_data_o,
  output logic                       id_data_ready,
  output trace_output                id_data_o,
  output logic                       ex_data_ready,
  output trace_output                ex_data_o,
  output logic                       ex_overflow
);

  // IF stage status is observed by the core interface but not needed for tracing
  logic unused_if_status;
  assign unused_if_status = if_busy ^ if_ready;

  if_tracker u_if (
    .clk           (clk),
    .rst           (rst),
    .counter       (counter),
    .instr_req     (instr_req),
    .instr_grant   (instr_grant),
    .instr_rvalid  (instr_rvalid),
    .instr_addr    (instr_addr),
    .instr_rdata   (instr_rdata),
    .if_data_valid (if_data_valid),
    .if_data_o     (if_data_o)
  );

  id_tracker u_id (
    .clk                 (clk),
    .rst                 (rst),
    .counter             (counter),
    .if_data_valid       (if_data_valid),
    .if_data_o           (if_data_o),
    .id_ready            (id_ready),
    .jump_done           (jump_done),
    .is_decoding         (is_decoding),
    .illegal_instruction (illegal_instruction),
    .id_data_ready       (id_data_ready),
    .id_data_o           (id_data_o)
  );

  ex_tracker #(
    .DATA_ADDR_WIDTH (DATA_ADDR_WIDTH),
    .EX_FIFO_DEPTH   (EX_FIFO_DEPTH)
  ) u_ex (
    .clk               (clk),
    .rst               (rst),
    .counter           (counter),
    .id_data_ready     (id_data_ready),
    .id_data_o         (id_data_o),
    .ex_ready          (ex_ready),
    .data_mem_req      (data_mem_req),
    .data_mem_grant    (data_mem_grant),
    .data_mem_rvalid   (data_mem_rvalid),
    .data_mem_addr     (data_mem_addr),
    .wb_previous_end_i (wb_previous_end_i),
    .ex_data_ready     (ex_data_ready),
    .ex_data_o         (ex_data_o),
    .ex_overflow       (ex_overflow)
  );

endmodule

// File: tb/tb_if_id_ex_tracker.sv
// tb/tb_if_id_ex_tracker.sv - directed self-checking bench for if_id_ex_tracker
module tb_if_id_ex_tracker;
  import ryuki_datatypes::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [31:0] counter;
  logic               if_busy = 1'b0, if_ready = 1'b1;
  logic               instr_req = 1'b0, instr_grant = 1'b0, instr_rvalid = 1'b0;
  logic        [31:0] instr_addr = '0, instr_rdata = '0;
  logic               id_ready = 1'b0, jump_done = 1'b0, is_decoding = 1'b0;
  logic               illegal_instruction = 1'b0;
  logic               ex_ready = 1'b0, data_mem_req = 1'b0, data_mem_grant = 1'b0;
  logic               data_mem_rvalid = 1'b0;
  logic        [31:0] data_mem_addr = '0;
  logic signed [31:0] wb_previous_end_i = '0;
  logic               if_data_valid, id_data_ready, ex_data_ready, ex_overflow;
  trace_output        if_data_o, id_data_o, ex_data_o;

  int n_tests = 0;
  int n_fail  = 0;

  if_id_ex_tracker #(.DATA_ADDR_WIDTH(32), .EX_FIFO_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .counter(counter), .if_busy(if_busy), .if_ready(if_ready),
    .instr_req(instr_req), .instr_grant(instr_grant), .instr_rvalid(instr_rvalid),
    .instr_addr(instr_addr), .instr_rdata(instr_rdata), .id_ready(id_ready),
    .jump_done(jump_done), .is_decoding(is_decoding),
    .illegal_instruction(illegal_instruction), .ex_ready(ex_ready),
    .data_mem_req(data_mem_req), .data_mem_grant(data_mem_grant),
    .data_mem_rvalid(data_mem_rvalid), .data_mem_addr(data_mem_addr),
    .wb_previous_end_i(wb_previous_end_i), .if_data_valid(if_data_valid),
    .if_data_o(if_data_o), .id_data_ready(id_data_ready), .id_data_o(id_data_o),
    .ex_data_ready(ex_data_ready), .ex_data_o(ex_data_o), .ex_overflow(ex_overflow)
  );

  always #5 clk = ~clk;

  // System cycle counter as the core would present it
  always @(posedge clk or posedge rst) begin
    if (rst) counter <= -32'sd1;
    else     counter <= counter + 32'sd1;
  end

  task automatic check(input string tag, input logic [299:0] got, input logic [299:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic goto(input int n);
    int guard = 0;
    while (counter != n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("goto_counter", counter, n);
  endtask

  // Fetch completes in one cycle, decode completes in the following one
  task automatic run_instr(input logic [31:0] a, input logic [31:0] w, input logic illegal);
    instr_req = 1'b1; instr_grant = 1'b1; instr_rvalid = 1'b1;
    instr_addr = a; instr_rdata = w;
    @(negedge clk);
    instr_req = 1'b0; instr_grant = 1'b0; instr_rvalid = 1'b0;
    is_decoding = 1'b1; id_ready = 1'b1; illegal_instruction = illegal;
    @(negedge clk);
    is_decoding = 1'b0; id_ready = 1'b0; illegal_instruction = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int drained;
    repeat (2) @(negedge clk);
    check("rst_if_rec", if_data_o, TRACE_RESET);
    check("rst_id_rec", id_data_o, TRACE_RESET);
    check("rst_ex_rec", ex_data_o, TRACE_RESET);
    check("rst_pulses", {if_data_valid, id_data_ready, ex_data_ready, ex_overflow}, 4'b0000);
    rst = 1'b0;

    // Fetch 0x80: req+grant at 3, rvalid at 5
    goto(3);
    instr_req = 1'b1; instr_grant = 1'b1; instr_addr = 32'h80;
    @(negedge clk);
    instr_req = 1'b0; instr_grant = 1'b0; instr_addr = 32'h0;
    goto(5);
    check("if_no_early_valid", if_data_valid, 1'b0);
    instr_rvalid = 1'b1; instr_rdata = 32'h13;
    @(negedge clk);
    instr_rvalid = 1'b0;
    check("if1_valid", if_data_valid, 1'b1);
    check("if1_addr", if_data_o.addr, 32'h80);
    check("if1_instr", if_data_o.instruction, 32'h13);
    check("if1_start", if_data_o.if_start, 3);
    check("if1_end", if_data_o.if_end, 5);
    is_decoding = 1'b1;
    wb_previous_end_i = 4;
    @(negedge clk);
    // counter 7: finish decode of 0x80, fetch 0x84 in a single cycle
    check("if_valid_pulse", if_data_valid, 1'b0);
    id_ready = 1'b1;
    instr_req = 1'b1; instr_grant = 1'b1; instr_rvalid = 1'b1;
    instr_addr = 32'h84; instr_rdata = 32'h0000_2083;
    @(negedge clk);
    // counter 8
    instr_req = 1'b0; instr_grant = 1'b0; instr_rvalid = 1'b0;
    is_decoding = 1'b0; id_ready = 1'b0;
    check("id1_ready", id_data_ready, 1'b1);
    check("id1_start", id_data_o.id_start, 6);
    check("id1_end", id_data_o.id_end, 7);
    check("if2_valid", if_data_valid, 1'b1);
    check("if2_times", {if_data_o.if_start, if_data_o.if_end}, {32'sd7, 32'sd7});
    ex_ready = 1'b1;
    @(negedge clk);
    // counter 9
    ex_ready = 1'b0;
    check("ex1_ready", ex_data_ready, 1'b1);
    check("ex1_addr", ex_data_o.addr, 32'h80);
    check("ex1_start", ex_data_o.ex_start, 7);
    check("ex1_end", ex_data_o.ex_end, 8);
    check("ex1_flags", {ex_data_o.valid, ex_data_o.is_mem}, 2'b10);
    is_decoding = 1'b1; id_ready = 1'b1;
    wb_previous_end_i = 12;
    @(negedge clk);
    // counter 10: load granted as the record reaches EX
    is_decoding = 1'b0; id_ready = 1'b0;
    check("id2_ready", id_data_ready, 1'b1);
    check("id2_times", {id_data_o.id_start, id_data_o.id_end}, {32'sd9, 32'sd9});
    data_mem_req = 1'b1; data_mem_grant = 1'b1; data_mem_addr = 32'h1000;
    @(negedge clk);
    data_mem_req = 1'b0; data_mem_grant = 1'b0; data_mem_addr = 32'h0;
    goto(13);
    check("ex2_waits_rvalid", ex_data_ready, 1'b0);
    data_mem_rvalid = 1'b1;
    @(negedge clk);
    data_mem_rvalid = 1'b0;
    check("ex2_ready", ex_data_ready, 1'b1);
    check("ex2_addr", ex_data_o.addr, 32'h84);
    check("ex2_mem_addr", ex_data_o.mem_addr, 32'h1000);
    check("ex2_is_mem", ex_data_o.is_mem, 1'b1);
    check("ex2_start", ex_data_o.ex_start, 12);
    check("ex2_end", ex_data_o.ex_end, 13);

    // Illegal instruction: decode completes but produces nothing
    goto(15);
    run_instr(32'h88, 32'hFFFF_FFFF, 1'b1);
    check("illegal_no_id", id_data_ready, 1'b0);
    // Jump discards a record that never started decoding
    instr_req = 1'b1; instr_grant = 1'b1; instr_rvalid = 1'b1; instr_addr = 32'h8C;
    @(negedge clk);
    instr_req = 1'b0; instr_grant = 1'b0; instr_rvalid = 1'b0;
    jump_done = 1'b1;
    @(negedge clk);
    jump_done = 1'b0; is_decoding = 1'b1; id_ready = 1'b1;
    @(negedge clk);
    is_decoding = 1'b0; id_ready = 1'b0;
    check("jump_no_id", id_data_ready, 1'b0);
    check("jump_no_ex", ex_data_ready, 1'b0);

    // Fill the EX queue to capacity, then one more
    wb_previous_end_i = 0;
    for (int i = 0; i < 256; i++) run_instr(32'h200 + 32'(i) * 4, 32'(i), 1'b0);
    @(negedge clk);
    check("fifo_full_no_ovf", ex_overflow, 1'b0);
    run_instr(32'h600, 32'h600, 1'b0);
    @(negedge clk);
    check("fifo_overflow", ex_overflow, 1'b1);

    // Drain in order; the dropped record must not appear
    ex_ready = 1'b1;
    drained = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (ex_data_ready) begin
        check("drain_addr", ex_data_o.addr, 32'h200 + 32'(drained) * 4);
        drained++;
      end
    end
    ex_ready = 1'b0;
    check("drain_count", drained, 256);
    check("drain_last_instr", ex_data_o.instruction, 32'd255);
    check("overflow_sticky", ex_overflow, 1'b1);

    // Reset in the middle of a load
    run_instr(32'hA0, 32'h55, 1'b0);
    data_mem_req = 1'b1; data_mem_grant = 1'b1; data_mem_addr = 32'h2000;
    @(negedge clk);
    data_mem_req = 1'b0; data_mem_grant = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ovf", ex_overflow, 1'b0);
    check("mid_rst_pulses", {if_data_valid, id_data_ready, ex_data_ready}, 3'b000);
    check("mid_rst_if_rec", if_data_o, TRACE_RESET);
    check("mid_rst_id_rec", id_data_o, TRACE_RESET);
    check("mid_rst_ex_rec", ex_data_o, TRACE_RESET);
    @(negedge clk);
    rst = 1'b0;

    // Fresh trace after reset
    goto(2);
    instr_req = 1'b1; instr_grant = 1'b1; instr_addr = 32'hC0;
    @(negedge clk);
    instr_req = 1'b0; instr_grant = 1'b0;
    instr_rvalid = 1'b1; instr_rdata = 32'h33;
    @(negedge clk);
    // counter 4
    instr_rvalid = 1'b0;
    check("post_if_addr", if_data_o.addr, 32'hC0);
    check("post_if_times", {if_data_o.if_start, if_data_o.if_end}, {32'sd2, 32'sd3});
    is_decoding = 1'b1;
    @(negedge clk);
    id_ready = 1'b1;
    @(negedge clk);
    // counter 6
    is_decoding = 1'b0; id_ready = 1'b0;
    check("post_id_times", {id_data_o.id_start, id_data_o.id_end}, {32'sd4, 32'sd5});
    ex_ready = 1'b1;
    @(negedge clk);
    ex_ready = 1'b0;
    check("post_ex_ready", ex_data_ready, 1'b1);
    check("post_ex_times", {ex_data_o.ex_start, ex_data_o.ex_end}, {32'sd5, 32'sd6});
    check("post_ex_not_mem", {ex_data_o.is_mem, ex_data_o.mem_addr}, 33'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
